fetch_unit: RTL and testbench



---
 rtl/fetch_pkg.sv | 21 ++
 rtl/fetch_queue.sv | 73 +++++++
 rtl/fetch_unit.sv | 127 ++++++++++++
 tb/tb_fetch_unit.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch stage.
package fetch_pkg;

    localparam int unsigned FETCH_ADDR_W   = 32;
    localparam int unsigned FETCH_INSTR_W  = 32;
    localparam int unsigned FETCH_FQ_DEPTH = 4;
    localparam logic [FETCH_ADDR_W-1:0] FETCH_RESET_PC = 32'h8000_0000;

    typedef enum logic [1:0] {
        F_REQ,
        F_WAIT,
        F_DRAIN
    } fetch_state_t;

    // Default-width entry; the top re-declares it when widths are overridden.
    typedef struct packed {
        logic [FETCH_ADDR_W-1:0]  pc;
        logic [FETCH_INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// In-order circular queue of fetched {pc, instr} entries with flush.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH   = FETCH_FQ_DEPTH,
    parameter type         entry_t = fetch_entry_t,
    parameter int unsigned CNT_W   = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push,
    input  entry_t           push_entry,
    input  logic             pop,
    input  logic             flush,
    output logic [CNT_W-1:0] count,
    output entry_t           head
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             full;
    logic             empty;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign pop_ok  = pop && !empty && !flush;
    assign push_ok = push && (!full || pop_ok) && !flush;

    // NOTE: storage has no reset; validity is tracked by count_q, and leaving
    // the array unreset keeps it mappable onto plain flops/RAM without reset fan-out.
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= push_entry;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            // DEPTH is a power of two, so pointers wrap by natural overflow.
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign count = count_q;
    assign head  = mem[rd_ptr_q];

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, issues one I$ request at a time, queues
// returned instructions for decode and discards stale work on redirect.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH  = FETCH_ADDR_W,
    parameter int unsigned           INSTR_WIDTH = FETCH_INSTR_W,
    parameter int unsigned           FQ_DEPTH    = FETCH_FQ_DEPTH,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = FETCH_RESET_PC
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   redirect_valid_i,
    input  logic [ADDR_WIDTH-1:0]  redirect_pc_i,
    output logic                   icache_req_valid_o,
    output logic [ADDR_WIDTH-1:0]  icache_addr_o,
    input  logic                   icache_req_ready_i,
    input  logic                   icache_resp_valid_i,
    input  logic [INSTR_WIDTH-1:0] icache_resp_instr_i,
    output logic                   icache_resp_ready_o,
    output logic                   fetch_valid_o,
    output logic [INSTR_WIDTH-1:0] fetch_instr_o,
    output logic [ADDR_WIDTH-1:0]  fetch_pc_o,
    input  logic                   decode_ready_i
);

    localparam int unsigned CNT_W = $clog2(FQ_DEPTH + 1);

    typedef struct packed {
        logic [ADDR_WIDTH-1:0]  pc;
        logic [INSTR_WIDTH-1:0] instr;
    } entry_t;

    fetch_state_t          state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [ADDR_WIDTH-1:0] req_pc_q, req_pc_d;

    logic                  req_hs;
    logic                  resp_hs;
    logic                  fq_push;
    logic                  fq_pop;
    logic [CNT_W-1:0]      fq_count;
    entry_t                fq_push_entry;
    entry_t                fq_head;

    // Request valid is gated by reset so it reads 0 while rst_ni is low;
    // a free queue slot is reserved when the request is issued.
    assign icache_req_valid_o  = rst_ni && (state_q == F_REQ) && (fq_count < CNT_W'(FQ_DEPTH));
    assign icache_addr_o       = pc_q;
    assign icache_resp_ready_o = (state_q == F_WAIT) || (state_q == F_DRAIN);

    assign req_hs  = icache_req_valid_o && icache_req_ready_i;
    assign resp_hs = icache_resp_valid_i && icache_resp_ready_o;

    // NOTE: every always_comb output gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        req_pc_d = req_pc_q;
        fq_push  = 1'b0;

        case (state_q)
            F_REQ: begin
                if (req_hs) begin
                    req_pc_d = pc_q;
                    pc_d     = pc_q + ADDR_WIDTH'(4);
                    state_d  = redirect_valid_i ? F_DRAIN : F_WAIT;
                end
            end
            F_WAIT: begin
                if (redirect_valid_i) begin
                    state_d = resp_hs ? F_REQ : F_DRAIN;
                end else if (resp_hs) begin
                    fq_push = 1'b1;
                    state_d = F_REQ;
                end
            end
            F_DRAIN: begin
                if (resp_hs) begin
                    state_d = F_REQ;
                end
            end
            default: state_d = F_REQ;
        endcase

        if (redirect_valid_i) begin
            pc_d = redirect_pc_i & ~ADDR_WIDTH'(3);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= F_REQ;
            pc_q     <= RESET_PC;
            req_pc_q <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            req_pc_q <= req_pc_d;
        end
    end

    assign fq_push_entry = '{pc: req_pc_q, instr: icache_resp_instr_i};
    assign fq_pop        = decode_ready_i && fetch_valid_o;

    fetch_queue #(
        .DEPTH   (FQ_DEPTH),
        .entry_t (entry_t),
        .CNT_W   (CNT_W)
    ) u_fetch_queue (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .push       (fq_push),
        .push_entry (fq_push_entry),
        .pop        (fq_pop),
        .flush      (redirect_valid_i),
        .count      (fq_count),
        .head       (fq_head)
    );

    // Head fields are forced to zero when empty so stale storage never shows.
    assign fetch_valid_o = (fq_count != '0);
    assign fetch_instr_o = fetch_valid_o ? fq_head.instr : '0;
    assign fetch_pc_o    = fetch_valid_o ? fq_head.pc : '0;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed, table-driven bench for fetch_unit with an I$ driven cycle by cycle.
module tb_fetch_unit;

    logic        clk_i;
    logic        rst_ni;
    logic        redirect_valid_i;
    logic [31:0] redirect_pc_i;
    logic        icache_req_valid_o;
    logic [31:0] icache_addr_o;
    logic        icache_req_ready_i;
    logic        icache_resp_valid_i;
    logic [31:0] icache_resp_instr_i;
    logic        icache_resp_ready_o;
    logic        fetch_valid_o;
    logic [31:0] fetch_instr_o;
    logic [31:0] fetch_pc_o;
    logic        decode_ready_i;

    int tests_run = 0;
    int tests_failed = 0;

    fetch_unit dut (
        .clk_i               (clk_i),
        .rst_ni              (rst_ni),
        .redirect_valid_i    (redirect_valid_i),
        .redirect_pc_i       (redirect_pc_i),
        .icache_req_valid_o  (icache_req_valid_o),
        .icache_addr_o       (icache_addr_o),
        .icache_req_ready_i  (icache_req_ready_i),
        .icache_resp_valid_i (icache_resp_valid_i),
        .icache_resp_instr_i (icache_resp_instr_i),
        .icache_resp_ready_o (icache_resp_ready_o),
        .fetch_valid_o       (fetch_valid_o),
        .fetch_instr_o       (fetch_instr_o),
        .fetch_pc_o          (fetch_pc_o),
        .decode_ready_i      (decode_ready_i)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // One cycle: inputs driven this cycle, outputs expected this cycle.
    typedef struct {
        logic        rd;
        logic [31:0] rpc;
        logic        rrdy;
        logic        rv;
        logic [31:0] ri;
        logic        dec;
        logic        e_rv;
        logic [31:0] e_addr;
        logic        e_rr;
        logic        e_fv;
        logic [31:0] e_pc;
        logic [31:0] e_fi;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic rd, input logic [31:0] rpc, input logic rrdy,
                                input logic rv, input logic [31:0] ri, input logic dec,
                                input logic e_rv, input logic [31:0] e_addr, input logic e_rr,
                                input logic e_fv, input logic [31:0] e_pc, input logic [31:0] e_fi);
        vec_t v;
        v.rd = rd; v.rpc = rpc; v.rrdy = rrdy; v.rv = rv; v.ri = ri; v.dec = dec;
        v.e_rv = e_rv; v.e_addr = e_addr; v.e_rr = e_rr;
        v.e_fv = e_fv; v.e_pc = e_pc; v.e_fi = e_fi;
        return v;
    endfunction

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s[%0d]: got %h, expected %h", name, idx, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input int idx, input logic e_rv, input logic [31:0] e_addr,
                              input logic e_rr, input logic e_fv, input logic [31:0] e_pc,
                              input logic [31:0] e_fi);
        check({tag, ".req_valid"},  idx, 32'(icache_req_valid_o),  32'(e_rv));
        check({tag, ".addr"},       idx, icache_addr_o,            e_addr);
        check({tag, ".resp_ready"}, idx, 32'(icache_resp_ready_o), 32'(e_rr));
        check({tag, ".fetch_valid"},idx, 32'(fetch_valid_o),       32'(e_fv));
        check({tag, ".fetch_pc"},   idx, fetch_pc_o,               e_pc);
        check({tag, ".fetch_instr"},idx, fetch_instr_o,            e_fi);
    endtask

    // Called at a negedge; drives, samples 1ns later, then waits for the next negedge.
    task automatic run_vec(input string tag, input int idx, input vec_t v);
        redirect_valid_i    = v.rd;
        redirect_pc_i       = v.rpc;
        icache_req_ready_i  = v.rrdy;
        icache_resp_valid_i = v.rv;
        icache_resp_instr_i = v.ri;
        decode_ready_i      = v.dec;
        #1;
        check_outs(tag, idx, v.e_rv, v.e_addr, v.e_rr, v.e_fv, v.e_pc, v.e_fi);
        @(negedge clk_i);
    endtask

    initial begin
        rst_ni              = 1'b0;
        redirect_valid_i    = 1'b0;
        redirect_pc_i       = '0;
        icache_req_ready_i  = 1'b0;
        icache_resp_valid_i = 1'b0;
        icache_resp_instr_i = '0;
        decode_ready_i      = 1'b0;

        // Sequential fetch with 1-cycle I$ latency, decode always ready.
        vecs.push_back(mk(0, 0, 1, 0, 0,            1, 1, 32'h8000_0000, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 32'hA0A0_0000, 1, 0, 32'h8000_0004, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0,            1, 1, 32'h8000_0004, 0, 1, 32'h8000_0000, 32'hA0A0_0000));
        vecs.push_back(mk(0, 0, 0, 1, 32'hA1A1_0001, 1, 0, 32'h8000_0008, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0,            1, 1, 32'h8000_0008, 0, 1, 32'h8000_0004, 32'hA1A1_0001));
        vecs.push_back(mk(0, 0, 0, 1, 32'hA2A2_0002, 1, 0, 32'h8000_000C, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0,            1, 1, 32'h8000_000C, 0, 1, 32'h8000_0008, 32'hA2A2_0002));
        vecs.push_back(mk(0, 0, 0, 0, 0,            0, 1, 32'h8000_000C, 0, 0, 0, 0));
        // Decode stalled: queue fills to 4, then requests stop.
        vecs.push_back(mk(0, 0, 1, 0, 0,            0, 1, 32'h8000_000C, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 32'hB000_0000, 0, 0, 32'h8000_0010, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0,            0, 1, 32'h8000_0010, 0, 1, 32'h8000_000C, 32'hB000_0000));
        vecs.push_back(mk(0, 0, 0, 1, 32'hB000_0001, 0, 0, 32'h8000_0014, 1, 1, 32'h8000_000C, 32'hB000_0000));
        vecs.push_back(mk(0, 0, 1, 0, 0,            0, 1, 32'h8000_0014, 0, 1, 32'h8000_000C, 32'hB000_0000));
        vecs.push_back(mk(0, 0, 0, 1, 32'hB000_0002, 0, 0, 32'h8000_0018, 1, 1, 32'h8000_000C, 32'hB000_0000));
        vecs.push_back(mk(0, 0, 1, 0, 0,            0, 1, 32'h8000_0018, 0, 1, 32'h8000_000C, 32'hB000_0000));
        vecs.push_back(mk(0, 0, 0, 1, 32'hB000_0003, 0, 0, 32'h8000_001C, 1, 1, 32'h8000_000C, 32'hB000_0000));
        vecs.push_back(mk(0, 0, 1, 0, 0,            0, 0, 32'h8000_001C, 0, 1, 32'h8000_000C, 32'hB000_0000));
        vecs.push_back(mk(0, 0, 1, 0, 0,            1, 0, 32'h8000_001C, 0, 1, 32'h8000_000C, 32'hB000_0000));
        // One pop frees a slot: exactly one more request.
        vecs.push_back(mk(0, 0, 1, 0, 0,            0, 1, 32'h8000_001C, 0, 1, 32'h8000_0010, 32'hB000_0001));
        vecs.push_back(mk(0, 0, 0, 1, 32'hB000_0004, 0, 0, 32'h8000_0020, 1, 1, 32'h8000_0010, 32'hB000_0001));
        vecs.push_back(mk(0, 0, 1, 0, 0,            0, 0, 32'h8000_0020, 0, 1, 32'h8000_0010, 32'hB000_0001));
        vecs.push_back(mk(0, 0, 0, 0, 0,            1, 0, 32'h8000_0020, 0, 1, 32'h8000_0010, 32'hB000_0001));
        vecs.push_back(mk(0, 0, 0, 0, 0,            1, 1, 32'h8000_0020, 0, 1, 32'h8000_0014, 32'hB000_0002));
        vecs.push_back(mk(0, 0, 0, 0, 0,            1, 1, 32'h8000_0020, 0, 1, 32'h8000_0018, 32'hB000_0003));
        vecs.push_back(mk(0, 0, 0, 0, 0,            1, 1, 32'h8000_0020, 0, 1, 32'h8000_001C, 32'hB000_0004));

        // Reset values while held in reset.
        repeat (2) @(negedge clk_i);
        #1;
        check_outs("reset", 0, 0, 32'h8000_0000, 0, 0, 0, 0);
        @(negedge clk_i);
        rst_ni = 1'b1;

        foreach (vecs[i]) run_vec("tbl", i, vecs[i]);

        // Redirect in F_WAIT to a misaligned target; following response dropped.
        run_vec("redir_wait", 0, mk(0, 0, 1, 0, 0, 0, 1, 32'h8000_0020, 0, 0, 0, 0));
        run_vec("redir_wait", 1, mk(1, 32'h0000_1002, 0, 0, 0, 0, 0, 32'h8000_0024, 1, 0, 0, 0));
        run_vec("redir_wait", 2, mk(0, 0, 0, 1, 32'hDEAD_0001, 0, 0, 32'h0000_1000, 1, 0, 0, 0));
        run_vec("redir_wait", 3, mk(0, 0, 1, 0, 0, 0, 1, 32'h0000_1000, 0, 0, 0, 0));
        run_vec("redir_wait", 4, mk(0, 0, 0, 1, 32'hC000_0000, 0, 0, 32'h0000_1004, 1, 0, 0, 0));
        run_vec("redir_wait", 5, mk(0, 0, 1, 0, 0, 0, 1, 32'h0000_1004, 0, 1, 32'h0000_1000, 32'hC000_0000));

        // Redirect + response + pop in the same cycle, then redirect in F_REQ without handshake.
        run_vec("redir_resp", 0, mk(1, 32'h0000_2000, 0, 1, 32'hC000_0001, 1, 0, 32'h0000_1008, 1, 1, 32'h0000_1000, 32'hC000_0000));
        run_vec("redir_resp", 1, mk(1, 32'h0000_3000, 0, 0, 0, 0, 1, 32'h0000_2000, 0, 0, 0, 0));

        // Redirect with handshake -> F_DRAIN; a redirect while draining retargets the PC.
        run_vec("redir_hs", 0, mk(1, 32'h5000_0000, 1, 0, 0, 0, 1, 32'h0000_3000, 0, 0, 0, 0));
        run_vec("redir_hs", 1, mk(1, 32'h4000_0007, 0, 0, 0, 0, 0, 32'h5000_0000, 1, 0, 0, 0));
        run_vec("redir_hs", 2, mk(0, 0, 0, 1, 32'hBAD0_0001, 0, 0, 32'h4000_0004, 1, 0, 0, 0));
        run_vec("redir_hs", 3, mk(0, 0, 1, 0, 0, 0, 1, 32'h4000_0004, 0, 0, 0, 0));
        run_vec("redir_hs", 4, mk(0, 0, 0, 1, 32'hE000_0000, 0, 0, 32'h4000_0008, 1, 0, 0, 0));
        run_vec("redir_hs", 5, mk(0, 0, 0, 0, 0, 1, 1, 32'h4000_0008, 0, 1, 32'h4000_0004, 32'hE000_0000));

        // PC wrap from 0xFFFF_FFFC to 0.
        run_vec("wrap", 0, mk(1, 32'hFFFF_FFFE, 0, 0, 0, 0, 1, 32'h4000_0008, 0, 0, 0, 0));
        run_vec("wrap", 1, mk(0, 0, 1, 0, 0, 0, 1, 32'hFFFF_FFFC, 0, 0, 0, 0));
        run_vec("wrap", 2, mk(0, 0, 0, 1, 32'hF000_0000, 0, 0, 32'h0000_0000, 1, 0, 0, 0));
        run_vec("wrap", 3, mk(0, 0, 1, 0, 0, 0, 1, 32'h0000_0000, 0, 1, 32'hFFFF_FFFC, 32'hF000_0000));

        // Asynchronous reset in the middle of an F_WAIT cycle.
        icache_req_ready_i  = 1'b0;
        icache_resp_valid_i = 1'b0;
        decode_ready_i      = 1'b0;
        #1;
        check_outs("async_pre", 0, 0, 32'h0000_0004, 1, 1, 32'hFFFF_FFFC, 32'hF000_0000);
        #1;
        rst_ni = 1'b0;
        #1;
        check_outs("async_rst", 0, 0, 32'h8000_0000, 0, 0, 0, 0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        #1;
        check_outs("post_rst", 0, 1, 32'h8000_0000, 0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
